// File: rtl/irq_timer_pkg.sv
// ---------------------------------------------------------------------------
// irq_timer_pkg
// Shared definitions for the irq_timer block: register offsets within the
// 8-byte window, CTRL/STATUS bit positions, prescaler divide encodings and a
// helper that maps a PRE code to the prescaler terminal count.
// ---------------------------------------------------------------------------
package irq_timer_pkg;

   typedef logic [2:0] reg_off_t;

   // Register offsets (address[2:0])
   localparam reg_off_t REG_CNT_LO = 3'd0;
   localparam reg_off_t REG_CNT_HI = 3'd1;
   localparam reg_off_t REG_CTRL   = 3'd2;
   localparam reg_off_t REG_STATUS = 3'd3;
   localparam reg_off_t REG_MASK   = 3'd4;

   // CTRL bit positions
   localparam int CTRL_RUN_BIT  = 0;
   localparam int CTRL_AUTO_BIT = 1;
   localparam int CTRL_PRE_LSB  = 4;
   localparam int CTRL_PRE_MSB  = 5;

   // STATUS / MASK bit positions
   localparam int STAT_TMR_BIT = 0;
   localparam int STAT_EXT_BIT = 1;

   // PRE divide encodings
   localparam logic [1:0] PRE_DIV1   = 2'd0;
   localparam logic [1:0] PRE_DIV8   = 2'd1;
   localparam logic [1:0] PRE_DIV64  = 2'd2;
   localparam logic [1:0] PRE_DIV256 = 2'd3;

   // Terminal count (divide-1) of the 8-bit prescaler for a PRE code.
   function automatic logic [7:0] pre_terminal(input logic [1:0] pre);
      logic [7:0] term;
      case (pre)
         PRE_DIV1:  term = 8'd0;
         PRE_DIV8:  term = 8'd7;
         PRE_DIV64: term = 8'd63;
         default:   term = 8'd255;
      endcase
      return term;
   endfunction

endpackage

// File: rtl/irq_timer_presc.sv
// ---------------------------------------------------------------------------
// irq_timer_presc
// 8-bit prescaler for irq_timer. Counts only while run=1 and emits a one-cycle
// tick when the count reaches the terminal value selected by pre, then wraps.
// Ports:
//   clock   in  system clock
//   reset_n in  synchronous active-low reset
//   run     in  count enable (timer RUN bit)
//   clear   in  synchronous clear of the count (counter reload from CPU)
//   pre     in  divide select (0=/1, 1=/8, 2=/64, 3=/256)
//   tick    out counter decrement strobe
// ---------------------------------------------------------------------------
module irq_timer_presc
   import irq_timer_pkg::*;
(
   input  logic       clock,
   input  logic       reset_n,
   input  logic       run,
   input  logic       clear,
   input  logic [1:0] pre,
   output logic       tick
);

   logic [7:0] count_reg;
   logic [7:0] terminal;

   assign terminal = pre_terminal(pre);

   // ">=" rather than "==" so that switching PRE to a smaller divide while
   // the count is above the new terminal wraps at once instead of running
   // through 255 first.
   assign tick = run && (count_reg >= terminal);

   always_ff @(posedge clock) begin
      if (!reset_n || clear) begin
         count_reg <= 8'd0;
      end else if (tick) begin
         count_reg <= 8'd0;
      end else if (run) begin
         count_reg <= count_reg + 8'd1;
      end
   end

endmodule

// File: rtl/irq_timer.sv
// ---------------------------------------------------------------------------
// irq_timer
// Memory-mapped 16-bit down-counting timer with interrupt status/mask.
// Build option: define IRQ_TIMER_EXT_EN to add the external interrupt input
// (2-flop synchronizer + rising-edge detect setting STATUS[1]); otherwise
// ext_irq is ignored and STATUS[1]/MASK[1] are tied to 0.
// Ports:
//   clock   in  system clock
//   reset_n in  synchronous active-low reset
//   hold    in  CPU-run strobe, qualifies register writes
//   address in  16-bit CPU address (block decoded at BASE[15:3])
//   wdata   in  8-bit CPU write data
//   we      in  CPU write enable
//   ext_irq in  asynchronous external interrupt request
//   sel     out combinational address decode hit
//   rdata   out registered read data (0 when not selected)
//   intr    out level interrupt = |(STATUS & MASK)
// ---------------------------------------------------------------------------
module irq_timer
   import irq_timer_pkg::*;
#(
   parameter logic [15:0] BASE = 16'hD000
)
(
   input  logic        clock,
   input  logic        reset_n,
   input  logic        hold,
   input  logic [15:0] address,
   input  logic [7:0]  wdata,
   input  logic        we,
   input  logic        ext_irq,
   output logic        sel,
   output logic [7:0]  rdata,
   output logic        intr
);

`ifdef IRQ_TIMER_EXT_EN
   localparam logic [1:0] IMPL_BITS = 2'b11;
`else
   localparam logic [1:0] IMPL_BITS = 2'b01;
`endif

   logic [15:0] counter_reg;
   logic [7:0]  latch_lo_reg;
   logic [7:0]  latch_hi_reg;
   logic        run_reg;
   logic        auto_reg;
   logic [1:0]  pre_reg;
   logic [1:0]  status_reg;
   logic [1:0]  mask_reg;
   logic [7:0]  rdata_reg;

   logic        wr_en;
   logic        wr_lo, wr_hi, wr_ctrl, wr_stat, wr_mask;
   logic        tick;
   logic        underflow;
   logic        ext_rise;
   logic [1:0]  status_set;
   logic [1:0]  status_clr;
   logic [1:0]  status_next;
   logic [7:0]  rd_mux;

   assign sel   = (address[15:3] == BASE[15:3]);
   assign wr_en = sel && we && hold;

   assign wr_lo   = wr_en && (address[2:0] == REG_CNT_LO);
   assign wr_hi   = wr_en && (address[2:0] == REG_CNT_HI);
   assign wr_ctrl = wr_en && (address[2:0] == REG_CTRL);
   assign wr_stat = wr_en && (address[2:0] == REG_STATUS);
   assign wr_mask = wr_en && (address[2:0] == REG_MASK);

   irq_timer_presc u_presc (
      .clock   (clock),
      .reset_n (reset_n),
      .run     (run_reg),
      .clear   (wr_hi),
      .pre     (pre_reg),
      .tick    (tick)
   );

   // A CPU reload of the counter takes priority over an underflow in the
   // same cycle, so such an underflow has no side effects at all.
   assign underflow = tick && (counter_reg == 16'd0) && !wr_hi;

`ifdef IRQ_TIMER_EXT_EN
   logic ext_sync1_reg, ext_sync2_reg, ext_prev_reg;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         ext_sync1_reg <= 1'b0;
         ext_sync2_reg <= 1'b0;
         ext_prev_reg  <= 1'b0;
      end else begin
         ext_sync1_reg <= ext_irq;
         ext_sync2_reg <= ext_sync1_reg;
         ext_prev_reg  <= ext_sync2_reg;
      end
   end

   assign ext_rise = ext_sync2_reg && !ext_prev_reg;
`else
   logic unused_ext;
   assign unused_ext = ext_irq;
   assign ext_rise   = 1'b0;
`endif

   // Set has priority over write-1-to-clear.
   always_comb begin
      status_set               = 2'b00;
      status_set[STAT_TMR_BIT] = underflow;
      status_set[STAT_EXT_BIT] = ext_rise;
      status_clr  = wr_stat ? wdata[1:0] : 2'b00;
      status_next = ((status_reg & ~status_clr) | status_set) & IMPL_BITS;
   end

   always_comb begin
      rd_mux = 8'h00;
      case (address[2:0])
         REG_CNT_LO: rd_mux = counter_reg[7:0];
         REG_CNT_HI: rd_mux = counter_reg[15:8];
         REG_CTRL: begin
            rd_mux[CTRL_RUN_BIT]                = run_reg;
            rd_mux[CTRL_AUTO_BIT]               = auto_reg;
            rd_mux[CTRL_PRE_MSB:CTRL_PRE_LSB]   = pre_reg;
         end
         REG_STATUS: rd_mux = {6'd0, status_reg};
         REG_MASK:   rd_mux = {6'd0, mask_reg};
         default:    rd_mux = 8'h00;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         counter_reg  <= 16'd0;
         latch_lo_reg <= 8'd0;
         latch_hi_reg <= 8'd0;
         run_reg      <= 1'b0;
         auto_reg     <= 1'b0;
         pre_reg      <= 2'd0;
         status_reg   <= 2'd0;
         mask_reg     <= 2'd0;
         rdata_reg    <= 8'd0;
      end else begin
         if (wr_lo) begin
            latch_lo_reg <= wdata;
         end

         if (wr_hi) begin
            latch_hi_reg <= wdata;
            counter_reg  <= {wdata, latch_lo_reg};
         end else if (tick) begin
            if (counter_reg != 16'd0) begin
               counter_reg <= counter_reg - 16'd1;
            end else if (auto_reg) begin
               counter_reg <= {latch_hi_reg, latch_lo_reg};
            end
         end

         if (wr_ctrl) begin
            run_reg  <= wdata[CTRL_RUN_BIT];
            auto_reg <= wdata[CTRL_AUTO_BIT];
            pre_reg  <= wdata[CTRL_PRE_MSB:CTRL_PRE_LSB];
         end else if (underflow && !auto_reg) begin
            run_reg <= 1'b0;
         end

         if (wr_mask) begin
            mask_reg <= wdata[1:0] & IMPL_BITS;
         end

         status_reg <= status_next;
         rdata_reg  <= sel ? rd_mux : 8'h00;
      end
   end

   assign rdata = rdata_reg;
   assign intr  = |(status_reg & mask_reg);

endmodule

// File: tb/tb_irq_timer.sv
// ---------------------------------------------------------------------------
// tb_irq_timer
// Directed self-checking bench for irq_timer. Register reads push the
// expected value onto a scoreboard queue; the value is popped and compared
// once the registered rdata appears one clock later.
// ---------------------------------------------------------------------------
module tb_irq_timer;

   localparam logic [15:0] B = 16'hD000;
`ifdef IRQ_TIMER_EXT_EN
   localparam bit EXT = 1'b1;
`else
   localparam bit EXT = 1'b0;
`endif

   logic        clock   = 1'b0;
   logic        reset_n = 1'b0;
   logic        hold    = 1'b1;
   logic [15:0] address = 16'h0000;
   logic [7:0]  wdata   = 8'h00;
   logic        we      = 1'b0;
   logic        ext_irq = 1'b0;
   logic        sel;
   logic [7:0]  rdata;
   logic        intr;

   int n_err = 0;
   int n_chk = 0;

   typedef struct {
      string      tag;
      logic [7:0] exp;
   } sb_t;
   sb_t sb_q[$];

   irq_timer #(.BASE(B)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .hold    (hold),
      .address (address),
      .wdata   (wdata),
      .we      (we),
      .ext_irq (ext_irq),
      .sel     (sel),
      .rdata   (rdata),
      .intr    (intr)
   );

   always #5 clock = ~clock;

   initial begin
      #1ms;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [2:0] off, input logic [7:0] d, input logic h = 1'b1);
      address = B | {13'd0, off};
      wdata   = d;
      we      = 1'b1;
      hold    = h;
      step();
      $display("wr  off=%0d data=%h hold=%b", off, d, h);
      we      = 1'b0;
      hold    = 1'b1;
      address = 16'h0000;
   endtask

   task automatic rd(input logic [2:0] off, input logic [7:0] exp, input string tag);
      sb_t e;
      sb_t got;
      address = B | {13'd0, off};
      we      = 1'b0;
      e.tag   = tag;
      e.exp   = exp;
      sb_q.push_back(e);
      step();
      got = sb_q.pop_front();
      $display("rd  off=%0d data=%h exp=%h", off, rdata, got.exp);
      check(got.tag, {8'd0, rdata}, {8'd0, got.exp});
      address = 16'h0000;
   endtask

   initial begin
      // Reset state
      reset_n = 1'b0;
      step();
      step();
      check("rst_rdata", {8'd0, rdata}, 16'h0000);
      check("rst_intr", {15'd0, intr}, 16'h0000);
      reset_n = 1'b1;

      // Decode and all offsets read zero after reset
      address = B | 16'h0005;
      #1;
      check("sel_hit", {15'd0, sel}, 16'h0001);
      address = B + 16'h0008;
      #1;
      check("sel_miss", {15'd0, sel}, 16'h0000);
      for (int i = 0; i < 8; i++) begin
         rd(i[2:0], 8'h00, $sformatf("rst_off%0d", i));
      end

      // One-shot /1: flag and intr 4 cycles after CTRL write
      wr(3'd0, 8'h03);
      wr(3'd1, 8'h00);
      wr(3'd4, 8'h01);
      wr(3'd2, 8'h01);
      repeat (3) step();
      check("oneshot_intr_early", {15'd0, intr}, 16'h0000);
      step();
      check("oneshot_intr", {15'd0, intr}, 16'h0001);
      rd(3'd3, 8'h01, "oneshot_status");
      rd(3'd2, 8'h00, "oneshot_run_clr");
      rd(3'd0, 8'h00, "oneshot_cnt_lo");
      rd(3'd1, 8'h00, "oneshot_cnt_hi");

      // Write-1-to-clear drops intr on the next cycle
      wr(3'd3, 8'h01);
      check("clr_intr", {15'd0, intr}, 16'h0000);
      rd(3'd3, 8'h00, "clr_status");

      // Auto-reload /8: flag at 24, reload, repeat at 48
      wr(3'd0, 8'h02);
      wr(3'd1, 8'h00);
      wr(3'd2, 8'h13);
      repeat (23) step();
      check("auto_intr_early", {15'd0, intr}, 16'h0000);
      step();
      check("auto_intr", {15'd0, intr}, 16'h0001);
      rd(3'd0, 8'h02, "auto_reload");
      wr(3'd3, 8'h01);
      repeat (21) step();
      check("auto2_intr_early", {15'd0, intr}, 16'h0000);
      step();
      check("auto2_intr", {15'd0, intr}, 16'h0001);
      // Clear lands on the same edge as the third underflow
      repeat (23) step();
      wr(3'd3, 8'h01);
      check("setwins_intr", {15'd0, intr}, 16'h0001);
      rd(3'd3, 8'h01, "setwins_status");
      rd(3'd2, 8'h13, "auto_ctrl");
      wr(3'd2, 8'h00);
      wr(3'd3, 8'h01);
      check("stop_intr", {15'd0, intr}, 16'h0000);

      // CNT_HI write on an underflow edge: reload wins, no flag, RUN kept
      wr(3'd0, 8'h01);
      wr(3'd1, 8'h00);
      wr(3'd2, 8'h01);
      step();
      wr(3'd1, 8'h05);
      check("hiwins_intr", {15'd0, intr}, 16'h0000);
      rd(3'd1, 8'h05, "hiwins_cnt_hi");
      rd(3'd3, 8'h00, "hiwins_status");
      rd(3'd2, 8'h01, "hiwins_run");
      wr(3'd2, 8'h00);

      // Writes with hold=0 are ignored
      wr(3'd2, 8'h01, 1'b0);
      rd(3'd2, 8'h00, "hold0_ctrl");
      rd(3'd3, 8'h00, "hold0_status");

      // Unused offsets and unimplemented mask bits
      wr(3'd5, 8'hFF);
      rd(3'd5, 8'h00, "off5_ignored");
      wr(3'd4, 8'hFF);
      rd(3'd4, EXT ? 8'h03 : 8'h01, "mask_bits");

      // External interrupt pulse
      wr(3'd4, 8'h02);
      ext_irq = 1'b1;
      step();
      ext_irq = 1'b0;
      repeat (2) step();
      check("ext_intr", {15'd0, intr}, {15'd0, EXT});
      rd(3'd3, EXT ? 8'h02 : 8'h00, "ext_status");
      wr(3'd3, 8'h03);
      wr(3'd4, 8'h01);

      // Reset on the would-be underflow edge
      wr(3'd0, 8'h02);
      wr(3'd1, 8'h00);
      wr(3'd2, 8'h01);
      step();
      step();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      check("midrst_intr", {15'd0, intr}, 16'h0000);
      check("midrst_rdata", {8'd0, rdata}, 16'h0000);
      rd(3'd3, 8'h00, "midrst_status");
      rd(3'd2, 8'h00, "midrst_ctrl");
      rd(3'd4, 8'h00, "midrst_mask");
      rd(3'd0, 8'h00, "midrst_cnt_lo");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
